pca_regfile: RTL

//  PCA9685-compatible register bank sitting directly downstream of the i2c slave.

---
 rtl/pca_pkg.sv | 61 ++++++
 rtl/pca_led_reg.sv | 67 ++++++
 rtl/pca_regfile.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pca_pkg.sv
// ---------------------------------------------------------------------------
// pca_pkg
//   Shared definitions for the PCA9685-compatible register bank:
//   register addresses, reset values, FSM state encoding, LED field
//   encoding and the auto-increment pointer function.
// ---------------------------------------------------------------------------
package pca_pkg;

    localparam int LED_MAX = 16;  // register map is laid out for 16 channels

    // Register addresses
    localparam logic [7:0] ADDR_MODE1         = 8'h00;
    localparam logic [7:0] ADDR_MODE2         = 8'h01;
    localparam logic [7:0] ADDR_SUBADR1       = 8'h02;
    localparam logic [7:0] ADDR_ALLCALL       = 8'h05;
    localparam logic [7:0] ADDR_LED0_ON_L     = 8'h06;
    localparam logic [7:0] ADDR_LED_LAST      = 8'h45;
    localparam logic [7:0] ADDR_ALL_LED_ON_L  = 8'hFA;
    localparam logic [7:0] ADDR_ALL_LED_OFF_H = 8'hFD;
    localparam logic [7:0] ADDR_PRE_SCALE     = 8'hFE;
    localparam logic [7:0] ADDR_LAST          = 8'hFF;

    // Reset values
    localparam logic [7:0]      RST_MODE1     = 8'h11;
    localparam logic [7:0]      RST_MODE2     = 8'h04;
    localparam logic [7:0]      RST_LED_L     = 8'h00;
    localparam logic [4:0]      RST_ON_H      = 5'h00;
    localparam logic [4:0]      RST_OFF_H     = 5'h10;
    localparam logic [7:0]      RST_PRE_SCALE = 8'h1E;
    localparam logic [3:0][7:0] RST_SUBADR    = {8'hE0, 8'hE8, 8'hE4, 8'hE2};

    localparam logic [7:0] PRE_SCALE_MIN = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PTR   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    // Byte position inside one LED channel's 4-byte group
    typedef enum logic [1:0] {
        FLD_ON_L  = 2'd0,
        FLD_ON_H  = 2'd1,
        FLD_OFF_L = 2'd2,
        FLD_OFF_H = 2'd3
    } led_field_t;

    // Auto-increment: wraps after the last LED register and after 0xFF,
    // holds when AI is clear.
    function automatic logic [7:0] next_ptr(input logic [7:0] ptr, input logic ai);
        if (!ai) begin
            return ptr;
        end
        if ((ptr == ADDR_LED_LAST) || (ptr == ADDR_LAST)) begin
            return 8'h00;
        end
        return ptr + 8'h01;
    endfunction

endpackage

// File: rtl/pca_led_reg.sv
// ---------------------------------------------------------------------------
// pca_led_reg
//   One LED channel: ON_L, ON_H, OFF_L, OFF_H bytes. H bytes keep bits [4:0].
//   Ports:
//     clk_i, rst_i          clock, synchronous active-high reset
//     wr_en_i               write strobe for this channel
//     wr_field_i, wr_data_i byte to write and which field it lands in
//     rd_field_i            field selected for read-back
//     rd_data_o             read-back byte (H bits [7:5] read 0)
//     on_cnt_o, on_full_o   decoded {ON_H[3:0],ON_L} and ON_H[4]
//     off_cnt_o, off_full_o decoded {OFF_H[3:0],OFF_L} and OFF_H[4]
// ---------------------------------------------------------------------------
module pca_led_reg
    import pca_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  led_field_t  wr_field_i,
    input  logic [7:0]  wr_data_i,
    input  led_field_t  rd_field_i,
    output logic [7:0]  rd_data_o,
    output logic [11:0] on_cnt_o,
    output logic        on_full_o,
    output logic [11:0] off_cnt_o,
    output logic        off_full_o
);

    logic [7:0] on_l;
    logic [4:0] on_h;
    logic [7:0] off_l;
    logic [4:0] off_h;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            on_l  <= RST_LED_L;
            on_h  <= RST_ON_H;
            off_l <= RST_LED_L;
            off_h <= RST_OFF_H;
        end else if (wr_en_i) begin
            case (wr_field_i)
                FLD_ON_L:  on_l  <= wr_data_i;
                FLD_ON_H:  on_h  <= wr_data_i[4:0];
                FLD_OFF_L: off_l <= wr_data_i;
                FLD_OFF_H: off_h <= wr_data_i[4:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        rd_data_o = 8'h00;
        case (rd_field_i)
            FLD_ON_L:  rd_data_o = on_l;
            FLD_ON_H:  rd_data_o = {3'b000, on_h};
            FLD_OFF_L: rd_data_o = off_l;
            FLD_OFF_H: rd_data_o = {3'b000, off_h};
            default:   rd_data_o = 8'h00;
        endcase
    end

    assign on_cnt_o   = {on_h[3:0], on_l};
    assign on_full_o  = on_h[4];
    assign off_cnt_o  = {off_h[3:0], off_l};
    assign off_full_o = off_h[4];

endmodule

// File: rtl/pca_regfile.sv
// ---------------------------------------------------------------------------
// pca_regfile
//   PCA9685-compatible register bank fed by an i2c slave byte stream.
//   First written byte of a transaction is the register pointer, further
//   bytes are data. Read bytes are served on rd_req_i. MODE1.AI controls
//   pointer auto-increment.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     txn_start_i, txn_rw_i        address match pulse and its R/W bit
//     txn_stop_i                   STOP pulse
//     wr_valid_i, wr_data_i        master-written byte
//     rd_req_i                     request for next read byte
//     rd_data_o, rd_valid_o        read byte, valid one cycle after rd_req_i
//     on_cnt_o/on_full_o           per-LED ON count and full-on bit
//     off_cnt_o/off_full_o         per-LED OFF count and full-off bit
//     prescale_o                   PRE_SCALE
//     sleep_o, invrt_o, outdrv_o   MODE1[4], MODE2[4], MODE2[2]
// ---------------------------------------------------------------------------
module pca_regfile
    import pca_pkg::*;
#(
    parameter int NUM_LED = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    txn_start_i,
    input  logic                    txn_rw_i,
    input  logic                    txn_stop_i,
    input  logic                    wr_valid_i,
    input  logic [7:0]              wr_data_i,
    input  logic                    rd_req_i,
    output logic [7:0]              rd_data_o,
    output logic                    rd_valid_o,
    output logic [LED_MAX*12-1:0]   on_cnt_o,
    output logic [LED_MAX-1:0]      on_full_o,
    output logic [LED_MAX*12-1:0]   off_cnt_o,
    output logic [LED_MAX-1:0]      off_full_o,
    output logic [7:0]              prescale_o,
    output logic                    sleep_o,
    output logic                    invrt_o,
    output logic                    outdrv_o
);

    state_t          state, state_nxt;
    logic [7:0]      ptr;
    logic [7:0]      mode1;
    logic [7:0]      mode2;
    logic [7:0]      prescale;
    logic [3:0][7:0] subadr;

    logic            ptr_load;
    logic            wr_fire;
    logic            rd_fire;
    logic            led_hit;
    logic            all_hit;
    logic            sub_hit;
    logic [3:0]      led_idx;
    led_field_t      led_fld;
    led_field_t      all_fld;
    led_field_t      wr_fld;
    logic [7:0]      led_rd [LED_MAX];
    logic [7:0]      rd_mux;

    assign ptr_load = wr_valid_i && (state == ST_PTR);
    assign wr_fire  = wr_valid_i && (state == ST_WDATA);
    assign rd_fire  = rd_req_i   && (state == ST_RDATA);

    // Pointer decode: LED group index and byte-within-group
    assign led_hit = (ptr >= ADDR_LED0_ON_L) && (ptr <= ADDR_LED_LAST);
    assign all_hit = (ptr >= ADDR_ALL_LED_ON_L) && (ptr <= ADDR_ALL_LED_OFF_H);
    assign sub_hit = (ptr >= ADDR_SUBADR1) && (ptr <= ADDR_ALLCALL);
    assign led_idx = 4'((ptr - ADDR_LED0_ON_L) >> 2);
    assign led_fld = led_field_t'(2'(ptr - ADDR_LED0_ON_L));
    assign all_fld = led_field_t'(2'(ptr - ADDR_ALL_LED_ON_L));
    assign wr_fld  = all_hit ? all_fld : led_fld;

    // Channels beyond NUM_LED have no storage: writes vanish, reads give 0.
    for (genvar n = 0; n < LED_MAX; n++) begin : g_led
        if (n < NUM_LED) begin : g_inst
            logic we;
            assign we = wr_fire && (all_hit || (led_hit && (led_idx == 4'(n))));

            pca_led_reg u_led (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .wr_en_i    (we),
                .wr_field_i (wr_fld),
                .wr_data_i  (wr_data_i),
                .rd_field_i (led_fld),
                .rd_data_o  (led_rd[n]),
                .on_cnt_o   (on_cnt_o[n*12 +: 12]),
                .on_full_o  (on_full_o[n]),
                .off_cnt_o  (off_cnt_o[n*12 +: 12]),
                .off_full_o (off_full_o[n])
            );
        end else begin : g_none
            assign led_rd[n]             = 8'h00;
            assign on_cnt_o[n*12 +: 12]  = 12'h000;
            assign on_full_o[n]          = 1'b0;
            assign off_cnt_o[n*12 +: 12] = 12'h000;
            assign off_full_o[n]         = 1'b0;
        end
    end

    // Read mux; ALL_LED and unmapped addresses fall through to 0.
    always_comb begin
        // NOTE: default first, so every path assigns rd_mux and no latch is inferred.
        rd_mux = 8'h00;
        if (ptr == ADDR_MODE1) begin
            rd_mux = mode1;
        end else if (ptr == ADDR_MODE2) begin
            rd_mux = mode2;
        end else if (sub_hit) begin
            rd_mux = subadr[2'(ptr - ADDR_SUBADR1)];
        end else if (led_hit) begin
            rd_mux = led_rd[led_idx];
        end else if (ptr == ADDR_PRE_SCALE) begin
            rd_mux = prescale;
        end
    end

    // Next state: byte handling first, then STOP, then START (START wins).
    always_comb begin
        state_nxt = state;
        if ((state == ST_PTR) && wr_valid_i) begin
            state_nxt = ST_WDATA;
        end
        if (txn_stop_i) begin
            state_nxt = ST_IDLE;
        end
        if (txn_start_i) begin
            state_nxt = txn_rw_i ? ST_RDATA : ST_PTR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state      <= ST_IDLE;
            ptr        <= 8'h00;
            mode1      <= RST_MODE1;
            mode2      <= RST_MODE2;
            prescale   <= RST_PRE_SCALE;
            // NOTE: subadr has architected reset values, so this small array is reset like plain flops.
            subadr     <= RST_SUBADR;
            rd_data_o  <= 8'h00;
            rd_valid_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_valid_o <= rd_fire;
            if (rd_fire) begin
                rd_data_o <= rd_mux;
            end

            // AI is taken from MODE1 as held before this edge's write.
            if (ptr_load) begin
                ptr <= wr_data_i;
            end else if (wr_fire || rd_fire) begin
                ptr <= next_ptr(ptr, mode1[5]);
            end

            if (wr_fire) begin
                if (ptr == ADDR_MODE1) begin
                    mode1 <= {2'b00, wr_data_i[5:0]};  // RESTART/EXTCLK not supported
                end
                if (ptr == ADDR_MODE2) begin
                    mode2 <= wr_data_i;
                end
                if (sub_hit) begin
                    subadr[2'(ptr - ADDR_SUBADR1)] <= wr_data_i;
                end
                // Prescaler is only writable while the oscillator sleeps.
                if ((ptr == ADDR_PRE_SCALE) && mode1[4]) begin
                    prescale <= (wr_data_i < PRE_SCALE_MIN) ? PRE_SCALE_MIN : wr_data_i;
                end
            end
        end
    end

    assign prescale_o = prescale;
    assign sleep_o    = mode1[4];
    assign invrt_o    = mode2[4];
    assign outdrv_o   = mode2[2];

endmodule
